// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with frame-start sync, a one-word
// output holding register and overrun flagging when a finished word cannot be stored.
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_en,
    input  logic             frame_start,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    count_r, count_nxt_s;
    // The final bit is joined to the stored bits on the completing edge, so
    // the register never has to hold a full word's MSB beyond WIDTH-1 bits.
    logic [WIDTH-2:0] shift_r, shift_nxt_s;
    logic [WIDTH-1:0] word_s;
    logic             complete_s;

    // Next-state, counter and shift-register update.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        shift_nxt_s = shift_r;
        complete_s  = 1'b0;
        word_s      = {shift_r, serial_in};
        case (state_r)
            IDLE: begin
                if (bit_en && frame_start) begin
                    shift_nxt_s = {{(WIDTH-2){1'b0}}, serial_in};
                    count_nxt_s = CW'(1);
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (!bit_en) begin
                    state_nxt_s = SHIFT;
                end else if (frame_start) begin
                    shift_nxt_s = {{(WIDTH-2){1'b0}}, serial_in};
                    count_nxt_s = CW'(1);
                end else if (count_r == LAST_BIT) begin
                    complete_s  = 1'b1;
                    shift_nxt_s = word_s[WIDTH-2:0];
                    count_nxt_s = CW'(0);
                    state_nxt_s = IDLE;
                end else begin
                    shift_nxt_s = word_s[WIDTH-2:0];
                    count_nxt_s = count_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                count_nxt_s = CW'(0);
                shift_nxt_s = {(WIDTH-1){1'b0}};
            end
        endcase
    end

    // Receive-side state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= CW'(0);
            shift_r <= {(WIDTH-1){1'b0}};
            busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            shift_r <= shift_nxt_s;
            busy    <= (state_nxt_s == SHIFT);
        end
    end

    // Output holding register: a finished word replaces a pending one only
    // when that pending word is being accepted on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= {WIDTH{1'b0}};
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete_s) begin
                if (!data_valid || data_ready) begin
                    data_out   <= word_s;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end else begin
                data_valid <= data_valid;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed word table, hand-built corner sequences and
// random traffic, all compared against a bit-list reference model every cycle.
module tb_sipo_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in, bit_en, frame_start, data_ready;
    logic [W-1:0] data_out;
    logic         data_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    // reference model state
    int      m_bits[$];
    logic [W-1:0] m_out;
    logic    m_valid, m_busy, m_ovr;

    sipo_deser #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
        .frame_start(frame_start), .data_ready(data_ready), .data_out(data_out),
        .data_valid(data_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_out = '0; m_valid = 1'b0; m_busy = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic fs, input logic sin, input logic rdy);
        int   word;
        logic done;
        done = 1'b0;
        word = 0;
        if (en) begin
            if (fs) begin
                m_bits.delete();
                m_bits.push_back(int'(sin));
            end else if (m_bits.size() > 0) begin
                m_bits.push_back(int'(sin));
                if (m_bits.size() == W) begin
                    foreach (m_bits[k]) word += m_bits[k] * (1 << (W - 1 - k));
                    done = 1'b1;
                    m_bits.delete();
                end
            end
        end
        m_ovr = 1'b0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_out   = W'(word);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_busy = (m_bits.size() > 0);
    endtask

    task automatic check_model();
        check("data_out", 32'(data_out), 32'(m_out));
        check("data_valid", 32'(data_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic cycle(input logic en, input logic fs, input logic sin, input logic rdy);
        @(negedge clk);
        bit_en = en; frame_start = fs; serial_in = sin; data_ready = rdy;
        model_step(en, fs, sin, rdy);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit gaps, input logic rdy_last);
        for (int i = W - 1; i >= 0; i--) begin
            cycle(1'b1, (i == W - 1), word[i], (i == 0) ? rdy_last : 1'b0);
            if (gaps && i > 0) cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        end
    endtask

    typedef struct {
        logic [W-1:0] word;
        bit           gaps;
        logic         rdy_last;
        logic [W-1:0] exp_out;
        logic         exp_valid;
        logic         exp_ovr;
        bit           drain;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h12, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'h12, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h34, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h34, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1};

        reset = 1'b0; serial_in = 1'b0; bit_en = 1'b0; frame_start = 1'b0; data_ready = 1'b0;
        model_reset();
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // stray bits before any frame start are ignored
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        foreach (vecs[v]) begin
            send_word(vecs[v].word, vecs[v].gaps, vecs[v].rdy_last);
            check($sformatf("vec%0d_out", v), 32'(data_out), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_valid", v), 32'(data_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            if (vecs[v].drain) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b1);
                check($sformatf("vec%0d_drained", v), 32'(data_valid), 32'h0);
            end
        end

        // frame restart after 5 bits of 0xFF, then 0x81
        for (int i = 0; i < 5; i++) cycle(1'b1, (i == 0), 1'b1, 1'b0);
        send_word(8'h81, 1'b0, 1'b0);
        check("restart_out", 32'(data_out), 32'h81);
        check("restart_ovr", 32'(overrun), 32'h0);

        // back-to-back: next word starts on the cycle right after completion
        send_word(8'hC3, 1'b0, 1'b1);
        check("b2b_out", 32'(data_out), 32'hC3);

        // async reset with a pending word and a partial word in flight
        for (int i = 0; i < 4; i++) cycle(1'b1, (i == 0), 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_out", 32'(data_out), 32'h0);
        check("async_rst_valid", 32'(data_valid), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        send_word(8'h5A, 1'b0, 1'b0);
        check("post_rst_out", 32'(data_out), 32'h5A);
        check("post_rst_valid", 32'(data_valid), 32'h1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(9) < 7), ($urandom_range(15) < 2),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
